// File: rtl/ahb_data_slave.sv
// AHB-Lite data RAM slave with configurable wait states.
// Two-cycle ERROR response; writes land at the end of the data phase.
module ahb_data_slave #(
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        is_signed,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hready_out,
  output logic        hresp
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DONE,
    ERR1,
    ERR2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]    cnt;
  logic [1:0]    cnt_nx;
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic          accept;
  logic          bad;
  logic          can_take;
  logic [AW-3:0] wbase;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_data;
  logic [7:0]    rd_b;
  logic [15:0]   rd_h;
  logic [3:0]    be;
  logic          unused_htrans;

  logic [7:0] mem [MEM_BYTES];

  assign unused_htrans = htrans[0];

  assign can_take = (state == IDLE)
                  | (state == DONE)
                  | (state == ERR2);

  assign accept = hsel & htrans[1]
                & hready_in & ~reset
                & can_take;

  assign bad = (haddr[31:AW] != '0)
             | hsize[2]
             | (hsize == 3'd3)
             | ((hsize == 3'd1) & haddr[0])
             | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      WAIT: begin
        if (cnt == 2'd0) state_nx = DONE;
        else             cnt_nx   = cnt - 2'd1;
      end
      ERR1: state_nx = ERR2;
      default: begin
        state_nx = IDLE;
        if (accept) begin
          if (bad) begin
            state_nx = ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nx = WAIT;
            cnt_nx   = 2'(WAIT_STATES - 1);
          end else begin
            state_nx = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= haddr[AW-1:0];
      wr_q   <= hwrite;
      size_q <= hsize[1:0];
      sgn_q  <= is_signed;
    end
  end

  assign wbase = addr_q[AW-1:2];

  assign rd_word = {mem[{wbase, 2'd3}],
                    mem[{wbase, 2'd2}],
                    mem[{wbase, 2'd1}],
                    mem[{wbase, 2'd0}]};

  assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};
  assign rd_b     = rd_shift[7:0];
  assign rd_h     = addr_q[1] ? rd_word[31:16]
                              : rd_word[15:0];

  always_comb begin
    rd_data = '0;
    be      = 4'b0000;
    unique case (size_q)
      2'd0: begin
        rd_data = {{24{sgn_q & rd_b[7]}}, rd_b};
        be[addr_q[1:0]] = 1'b1;
      end
      2'd1: begin
        rd_data = {{16{sgn_q & rd_h[15]}}, rd_h};
        be = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        rd_data = rd_word;
        be      = 4'b1111;
      end
    endcase
  end

  // RAM is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (!reset && state == DONE && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[{wbase, 2'(i)}] <= hwdata[8*i +: 8];
      end
    end
  end

  assign hrdata = (state == DONE && !wr_q) ? rd_data
                                           : 32'h0;

  assign hready_out = !((state == WAIT) | (state == ERR1));
  assign hresp      = (state == ERR1) | (state == ERR2);

endmodule

// File: tb/tb_ahb_data_slave.sv
// Bench for ahb_data_slave: one instance with one wait state,
// one with zero wait states, scoreboard-checked transfers.
module tb_ahb_data_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic        is_signed [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hready_out[2];
  logic        hresp     [2];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        err;
    int          waits;
  } exp_t;

  exp_t sb[$];

  ahb_data_slave #(.MEM_BYTES(4096), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .hsel(hsel[0]),
    .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]),
    .is_signed(is_signed[0]), .hwdata(hwdata[0]),
    .hready_in(hready_out[0]), .hrdata(hrdata[0]),
    .hready_out(hready_out[0]), .hresp(hresp[0])
  );

  ahb_data_slave #(.MEM_BYTES(4096), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .hsel(hsel[1]),
    .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]),
    .is_signed(is_signed[1]), .hwdata(hwdata[1]),
    .hready_in(hready_out[1]), .hrdata(hrdata[1]),
    .hready_out(hready_out[1]), .hresp(hresp[1])
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus(int d);
    hsel[d]      = 1'b0;
    htrans[d]    = 2'd0;
    haddr[d]     = 32'h0;
    hwrite[d]    = 1'b0;
    hsize[d]     = 3'd2;
    is_signed[d] = 1'b0;
  endtask

  task automatic addr_phase(int d, logic [1:0] tr, logic wr,
                            logic [31:0] a, logic [2:0] sz, logic sg);
    hsel[d]      = 1'b1;
    htrans[d]    = tr;
    haddr[d]     = a;
    hwrite[d]    = wr;
    hsize[d]     = sz;
    is_signed[d] = sg;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic xfer(int d, string tag, logic wr, logic [31:0] a,
                      logic [2:0] sz, logic sg, logic [31:0] wd,
                      logic [31:0] exp_rd, logic exp_err, int exp_waits);
    exp_t e;
    exp_t g;
    int   n;
    logic ok;
    e.tag   = tag;
    e.rd    = wr ? 32'h0 : exp_rd;
    e.err   = exp_err;
    e.waits = exp_waits;
    sb.push_back(e);
    addr_phase(d, 2'd2, wr, a, sz, sg);
    step();
    idle_bus(d);
    hwdata[d] = wd;
    n  = 0;
    ok = 1'b1;
    while (hready_out[d] !== 1'b1 && n < 8) begin
      if (hresp[d] !== exp_err || hrdata[d] !== 32'h0) ok = 1'b0;
      n++;
      @(negedge clk);
    end
    g = sb.pop_front();
    chk({g.tag, "_waits"}, 32'(n), 32'(g.waits));
    chk({g.tag, "_stall"}, 32'(ok), 32'd1);
    chk({g.tag, "_resp"}, 32'(hresp[d]), 32'(g.err));
    chk({g.tag, "_rdata"}, hrdata[d], g.rd);
  endtask

  task automatic chk_idle(int d, string tag);
    chk({tag, "_rdy"}, 32'(hready_out[d]), 32'd1);
    chk({tag, "_resp"}, 32'(hresp[d]), 32'd0);
    chk({tag, "_rdata"}, hrdata[d], 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      idle_bus(d);
      hwdata[d] = 32'h0;
    end
    @(negedge clk);
    step();
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    reset = 1'b0;
    step();

    xfer(0, "w_dead", 1, 32'h10, 3'd2, 0, 32'hDEADBEEF, 0, 0, 1);
    xfer(0, "r_dead", 0, 32'h10, 3'd2, 0, 0, 32'hDEADBEEF, 0, 1);
    xfer(0, "w_zero", 1, 32'h10, 3'd2, 0, 32'h0, 0, 0, 1);
    xfer(0, "w_b13", 1, 32'h13, 3'd0, 0, 32'h80A5A5A5, 0, 0, 1);
    xfer(0, "r_b13s", 0, 32'h13, 3'd0, 1, 0, 32'hFFFFFF80, 0, 1);
    xfer(0, "r_b13u", 0, 32'h13, 3'd0, 0, 0, 32'h00000080, 0, 1);
    xfer(0, "r_w10", 0, 32'h10, 3'd2, 0, 0, 32'h80000000, 0, 1);
    xfer(0, "w_w14", 1, 32'h14, 3'd2, 0, 32'h00001234, 0, 0, 1);
    xfer(0, "w_h16", 1, 32'h16, 3'd1, 0, 32'h80015A5A, 0, 0, 1);
    xfer(0, "r_h16s", 0, 32'h16, 3'd1, 1, 0, 32'hFFFF8001, 0, 1);
    xfer(0, "r_h16u", 0, 32'h16, 3'd1, 0, 0, 32'h00008001, 0, 1);
    xfer(0, "r_h14s", 0, 32'h14, 3'd1, 1, 0, 32'h00001234, 0, 1);
    xfer(0, "r_w14", 0, 32'h14, 3'd2, 0, 0, 32'h80011234, 0, 1);
    xfer(0, "r_b15s", 0, 32'h15, 3'd0, 1, 0, 32'h00000012, 0, 1);

    xfer(0, "e_r12", 0, 32'h12, 3'd2, 0, 0, 0, 1, 1);
    xfer(0, "e_rtop", 0, 32'h1000, 3'd2, 0, 0, 0, 1, 1);
    xfer(0, "e_w12", 1, 32'h12, 3'd2, 0, 32'hFFFFFFFF, 0, 1, 1);
    xfer(0, "e_wh11", 1, 32'h11, 3'd1, 0, 32'hFFFFFFFF, 0, 1, 1);
    xfer(0, "e_wsz3", 1, 32'h10, 3'd3, 0, 32'hFFFFFFFF, 0, 1, 1);
    xfer(0, "e_wtop", 1, 32'h1010, 3'd2, 0, 32'hFFFFFFFF, 0, 1, 1);
    xfer(0, "r_w10b", 0, 32'h10, 3'd2, 0, 0, 32'h80000000, 0, 1);
    xfer(0, "r_w14b", 0, 32'h14, 3'd2, 0, 0, 32'h80011234, 0, 1);

    xfer(0, "w_w20", 1, 32'h20, 3'd2, 0, 32'h11223344, 0, 0, 1);
    step();
    addr_phase(0, 2'd2, 1, 32'h20, 3'd2, 0);
    step();
    chk("rst_wait_rdy", 32'(hready_out[0]), 32'd0);
    idle_bus(0);
    hwdata[0] = 32'hCAFEF00D;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle(0, "rst_abort");
    step();
    chk_idle(0, "rst_after");
    xfer(0, "r_w20", 0, 32'h20, 3'd2, 0, 0, 32'h11223344, 0, 1);
    step();

    reset = 1'b1;
    addr_phase(0, 2'd2, 0, 32'h20, 3'd2, 0);
    step();
    reset = 1'b0;
    idle_bus(0);
    chk_idle(0, "rst_noacc");

    addr_phase(0, 2'd0, 0, 32'h10, 3'd2, 0);
    step();
    chk_idle(0, "idle_sel");
    addr_phase(0, 2'd1, 0, 32'h10, 3'd2, 0);
    step();
    chk_idle(0, "busy_sel");
    addr_phase(0, 2'd2, 0, 32'h10, 3'd2, 0);
    hsel[0] = 1'b0;
    step();
    chk_idle(0, "nsel");
    idle_bus(0);
    step();
    chk_idle(0, "nsel2");

    addr_phase(1, 2'd2, 1, 32'h0, 3'd2, 0);
    step();
    chk("burst0_rdy", 32'(hready_out[1]), 32'd1);
    hwdata[1] = 32'h01020304;
    haddr[1]  = 32'h4;
    step();
    chk("burst1_rdy", 32'(hready_out[1]), 32'd1);
    hwdata[1] = 32'hA0B0C0D0;
    haddr[1]  = 32'h8;
    step();
    chk("burst2_rdy", 32'(hready_out[1]), 32'd1);
    chk("burst2_resp", 32'(hresp[1]), 32'd0);
    hwdata[1] = 32'h0F0E0D0C;
    idle_bus(1);
    step();
    chk_idle(1, "burst_end");
    xfer(1, "r_b0", 0, 32'h0, 3'd2, 0, 0, 32'h01020304, 0, 0);
    xfer(1, "r_b4", 0, 32'h4, 3'd2, 0, 0, 32'hA0B0C0D0, 0, 0);
    xfer(1, "r_b8", 0, 32'h8, 3'd2, 0, 0, 32'h0F0E0D0C, 0, 0);
    xfer(1, "r_b5s", 0, 32'h5, 3'd0, 1, 0, 32'hFFFFFFC0, 0, 0);
    xfer(1, "e_h3", 0, 32'h3, 3'd1, 0, 0, 0, 1, 1);
    xfer(1, "r_b8b", 0, 32'h8, 3'd2, 0, 0, 32'h0F0E0D0C, 0, 0);

    xfer(1, "w_w30", 1, 32'h30, 3'd2, 0, 32'h55667788, 0, 0, 0);
    step();
    addr_phase(1, 2'd2, 1, 32'h30, 3'd2, 0);
    step();
    chk("rst_done_rdy", 32'(hready_out[1]), 32'd1);
    idle_bus(1);
    hwdata[1] = 32'h99999999;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle(1, "rst_done");
    xfer(1, "r_w30", 0, 32'h30, 3'd2, 0, 0, 32'h55667788, 0, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
